// File: rtl/piso_pkg.sv
// Shared state encoding and width helper for the parallel-in/serial-out serializer.
package piso_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic int CNT_W(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Bit-position up-counter for the serializer; flags the last bit of a word.
module bit_counter
  import piso_pkg::*;
#(
  parameter int Size = 8
) (
  input  logic clk,
  input  logic clr,
  input  logic clear_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int W = CNT_W(Size);
  localparam logic [W-1:0] LAST = W'(Size - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out converter: one word in via valid/ready, one bit out per enabled
// falling edge, framed by sout_valid and closed by a one-cycle done pulse.
//
// state   | meaning
// S_IDLE  | waiting for a word, load_ready high
// S_SHIFT | word in flight, sout carries a payload bit
// S_DONE  | one-cycle completion, done pulse high
module piso_serializer
  import piso_pkg::*;
#(
  parameter int Size      = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            en,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [Size-1:0] din,
  output logic            sout,
  output logic            sout_valid,
  output logic            busy,
  output logic            done
);

  state_e          state_q;
  logic [Size-1:0] sr_q;
  logic            sout_q;
  logic            sout_valid_q;
  logic            done_q;
  logic            accept;
  logic            cnt_inc;
  logic            cnt_tc;

  assign accept  = (state_q == S_IDLE) && load_valid;
  assign cnt_inc = (state_q == S_SHIFT) && en && !cnt_tc;

  bit_counter #(
    .Size(Size)
  ) u_bit_counter (
    .clk    (clk),
    .clr    (clr),
    .clear_i(accept),
    .inc_i  (cnt_inc),
    .tc_o   (cnt_tc)
  );

  // sr_q holds only the bits not yet placed on sout, so the output bit is always at the same end.
  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= S_IDLE;
      sr_q         <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load_valid) begin
            state_q      <= S_SHIFT;
            sout_valid_q <= 1'b1;
            if (LSB_FIRST != 0) begin
              sout_q <= din[0];
              sr_q   <= din >> 1;
            end else begin
              sout_q <= din[Size-1];
              sr_q   <= din << 1;
            end
          end
        end
        S_SHIFT: begin
          if (en) begin
            if (cnt_tc) begin
              state_q      <= S_DONE;
              sout_q       <= 1'b0;
              sout_valid_q <= 1'b0;
              done_q       <= 1'b1;
            end else if (LSB_FIRST != 0) begin
              sout_q <= sr_q[0];
              sr_q   <= sr_q >> 1;
            end else begin
              sout_q <= sr_q[Size-1];
              sr_q   <= sr_q << 1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q      <= S_IDLE;
          sout_q       <= 1'b0;
          sout_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready = (state_q == S_IDLE);
  assign busy       = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: LSB-first and MSB-first serializers share stimulus; a timeline model
// predicts handshake/framing and queues the expected bit stream for each instance.
module tb_piso_serializer;

  localparam int SIZE = 8;

  typedef enum {M_IDLE, M_SHIFT, M_DONE} mstate_e;

  logic            clk = 1'b1;
  logic            clr = 1'b1;
  logic            en = 1'b0;
  logic            load_valid = 1'b0;
  logic [SIZE-1:0] din = '0;

  logic lr_l, sout_l, sv_l, busy_l, done_l;
  logic lr_m, sout_m, sv_m, busy_m, done_m;

  int      n_tests = 0;
  int      n_fail = 0;
  mstate_e m_state = M_IDLE;
  bit      m_new = 1'b0;
  int      m_left = 0;
  logic    q_l[$];
  logic    q_m[$];
  logic    last_l = 1'b0;
  logic    last_m = 1'b0;

  always #5 clk = ~clk;

  piso_serializer #(.Size(SIZE), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .clr(clr), .en(en), .load_valid(load_valid), .load_ready(lr_l),
    .din(din), .sout(sout_l), .sout_valid(sv_l), .busy(busy_l), .done(done_l)
  );

  piso_serializer #(.Size(SIZE), .LSB_FIRST(0)) u_msb (
    .clk(clk), .clr(clr), .en(en), .load_valid(load_valid), .load_ready(lr_m),
    .din(din), .sout(sout_m), .sout_valid(sv_m), .busy(busy_m), .done(done_m)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and advance the model to the state after the next falling edge.
  task automatic step(input logic lv, input logic [SIZE-1:0] d, input logic e, input logic c);
    @(posedge clk);
    #1;
    load_valid = lv;
    din        = d;
    en         = e;
    clr        = c;
    if (c) begin
      m_state = M_IDLE;
      m_new   = 1'b0;
      q_l.delete();
      q_m.delete();
    end else begin
      case (m_state)
        M_IDLE: begin
          m_new = 1'b0;
          if (lv) begin
            for (int i = 0; i < SIZE; i++) begin
              q_l.push_back(d[i]);
              q_m.push_back(d[SIZE-1-i]);
            end
            m_left  = SIZE;
            m_state = M_SHIFT;
            m_new   = 1'b1;
          end
        end
        M_SHIFT: begin
          m_new = e;
          if (e) begin
            m_left--;
            if (m_left == 0) m_state = M_DONE;
          end
        end
        default: begin
          m_new   = 1'b0;
          m_state = M_IDLE;
        end
      endcase
    end
  endtask

  task automatic send(input logic [SIZE-1:0] d, input int stall_after, input int stall_len,
                      input int abort_after, input logic junk);
    int   k;
    int   stalled;
    logic e;
    step(1'b1, d, 1'($urandom_range(0, 1)), 1'b0);
    k       = 1;
    stalled = 0;
    for (int cyc = 0; cyc < 4 * SIZE + 16 && m_state != M_IDLE; cyc++) begin
      if (abort_after > 0 && k == abort_after && m_state == M_SHIFT) begin
        step(1'b0, d, 1'b1, 1'b1);
        #1;
        chk("lsb sout_valid at clr", sv_l, 1'b0);
        chk("msb sout_valid at clr", sv_m, 1'b0);
        chk("lsb busy at clr", busy_l, 1'b0);
      end else if (k == stall_after && stalled < stall_len && m_state == M_SHIFT) begin
        step(junk, junk ? 8'hFF : SIZE'($urandom), 1'b0, 1'b0);
        stalled++;
      end else begin
        e = (m_state == M_DONE) ? 1'($urandom_range(0, 1)) : 1'b1;
        step(junk, junk ? 8'hFF : SIZE'($urandom), e, 1'b0);
        if (m_state == M_SHIFT && m_new) k++;
      end
    end
  endtask

  initial begin : monitor
    logic exp_l;
    logic exp_m;
    forever begin
      @(posedge clk);
      chk("lsb load_ready", lr_l, m_state == M_IDLE);
      chk("msb load_ready", lr_m, m_state == M_IDLE);
      chk("lsb busy", busy_l, m_state != M_IDLE);
      chk("msb busy", busy_m, m_state != M_IDLE);
      chk("lsb sout_valid", sv_l, m_state == M_SHIFT);
      chk("msb sout_valid", sv_m, m_state == M_SHIFT);
      chk("lsb done", done_l, m_state == M_DONE);
      chk("msb done", done_m, m_state == M_DONE);
      exp_l = 1'b0;
      exp_m = 1'b0;
      if (m_state == M_SHIFT) begin
        if (m_new) begin
          if (q_l.size() == 0 || q_m.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard underflow: queue empty at %0t", $time);
          end else begin
            last_l = q_l.pop_front();
            last_m = q_m.pop_front();
          end
        end
        exp_l = last_l;
        exp_m = last_m;
      end
      chk("lsb sout", sout_l, exp_l);
      chk("msb sout", sout_m, exp_m);
    end
  end

  initial begin : driver
    for (int i = 0; i < 3; i++) step(1'(i % 2), SIZE'($urandom), 1'b1, 1'b1);
    send(8'hA5, 0, 0, 0, 1'b0);
    send(8'h01, 0, 0, 0, 1'b0);
    send(8'hF0, 2, 3, 0, 1'b0);
    send(8'h3C, 0, 0, 0, 1'b1);
    send(8'hA5, 0, 0, 4, 1'b0);
    send(8'h5A, 0, 0, 0, 1'b0);
    for (int w = 0; w < 40; w++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step(1'b0, SIZE'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      send(SIZE'($urandom), $urandom_range(1, SIZE), $urandom_range(0, 3),
           ($urandom_range(0, 7) == 0) ? $urandom_range(1, SIZE) : 0, 1'($urandom_range(0, 1)));
    end
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("lsb queue drained", q_l.size(), 0);
    chk("msb queue drained", q_m.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
